// File: rtl/dma_cmd_sequencer_if.sv
// Command, burst-handshake and status bundle of the DMA command sequencer.
// DMA_SEQ_ABORT_EN adds the ch_abort / aborted pair.
interface dma_cmd_sequencer_if;
  logic        ch_start;
  logic [31:0] rd_start_addr;
  logic [31:0] wr_start_addr;
  logic [31:0] buffer_size;
  logic        set_int;
  logic        cmd_last;
  logic [27:0] next_addr;

  logic        rd_req;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_ack;

  logic        wr_req;
  logic [31:0] wr_addr;
  logic [7:0]  wr_len;
  logic        wr_ack;

  logic        desc_req;
  logic [31:0] desc_addr;
  logic        desc_ack;
  logic [31:0] desc_rd_addr;
  logic [31:0] desc_wr_addr;
  logic [31:0] desc_size;
  logic        desc_set_int;
  logic        desc_last;
  logic [27:0] desc_next;

  logic [15:0] buffer_count;
  logic [15:0] int_count;
  logic        irq;
  logic        busy;

`ifdef DMA_SEQ_ABORT_EN
  logic        ch_abort;
  logic        aborted;

  modport master (
    input  ch_start, rd_start_addr, wr_start_addr, buffer_size, set_int, cmd_last, next_addr,
    output rd_req, rd_addr, rd_len, input rd_ack,
    output wr_req, wr_addr, wr_len, input wr_ack,
    output desc_req, desc_addr,
    input  desc_ack, desc_rd_addr, desc_wr_addr, desc_size, desc_set_int, desc_last, desc_next,
    output buffer_count, int_count, irq, busy,
    input  ch_abort, output aborted
  );

  modport slave (
    output ch_start, rd_start_addr, wr_start_addr, buffer_size, set_int, cmd_last, next_addr,
    input  rd_req, rd_addr, rd_len, output rd_ack,
    input  wr_req, wr_addr, wr_len, output wr_ack,
    input  desc_req, desc_addr,
    output desc_ack, desc_rd_addr, desc_wr_addr, desc_size, desc_set_int, desc_last, desc_next,
    input  buffer_count, int_count, irq, busy,
    output ch_abort, input aborted
  );
`else
  modport master (
    input  ch_start, rd_start_addr, wr_start_addr, buffer_size, set_int, cmd_last, next_addr,
    output rd_req, rd_addr, rd_len, input rd_ack,
    output wr_req, wr_addr, wr_len, input wr_ack,
    output desc_req, desc_addr,
    input  desc_ack, desc_rd_addr, desc_wr_addr, desc_size, desc_set_int, desc_last, desc_next,
    output buffer_count, int_count, irq, busy
  );

  modport slave (
    output ch_start, rd_start_addr, wr_start_addr, buffer_size, set_int, cmd_last, next_addr,
    input  rd_req, rd_addr, rd_len, output rd_ack,
    input  wr_req, wr_addr, wr_len, output wr_ack,
    input  desc_req, desc_addr,
    output desc_ack, desc_rd_addr, desc_wr_addr, desc_size, desc_set_int, desc_last, desc_next,
    input  buffer_count, int_count, irq, busy
  );
`endif
endinterface

// File: rtl/dma_cmd_sequencer.sv
// DMA command sequencer: splits a command into read/write burst pairs and follows descriptor chains.
// Define DMA_SEQ_ABORT_EN to add the ch_abort input and aborted status output.
//
// state | meaning
// IDLE  | waiting for ch_start
// RD    | read-burst handshake
// WR    | write-burst handshake, advances addresses on ack
// DONE  | one-cycle command completion, counters and irq
// FETCH | descriptor-fetch handshake
module dma_cmd_sequencer #(
  parameter int BURST_MAX = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  dma_cmd_sequencer_if.master io_dma
);

  localparam logic [31:0] BURST_W = 32'(BURST_MAX);
  localparam logic [7:0]  BURST_L = 8'(BURST_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_DONE  = 3'd3,
    S_FETCH = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_src, w_src_nxt;
  logic [31:0] r_dst, w_dst_nxt;
  logic [31:0] r_rem, w_rem_nxt;
  logic [7:0]  r_len, w_len_nxt;
  logic        r_set_int, w_set_int_nxt;
  logic        r_last, w_last_nxt;
  logic [27:0] r_next, w_next_nxt;
  logic        r_rd_req, w_rd_req_nxt;
  logic        r_wr_req, w_wr_req_nxt;
  logic        r_desc_req, w_desc_req_nxt;
  logic [15:0] r_buf_cnt, w_buf_cnt_nxt;
  logic [15:0] r_int_cnt, w_int_cnt_nxt;
  logic        r_irq, w_irq_nxt;
  logic        r_busy, w_busy_nxt;

  logic        w_load;
  logic        w_enter_done;
  logic [31:0] w_ld_src, w_ld_dst, w_ld_size;
  logic        w_ld_int, w_ld_last;
  logic [27:0] w_ld_next;
  logic [31:0] w_rem_left;
  logic        w_abort_now;

  function automatic logic [7:0] f_burst(input logic [31:0] rem);
    return (rem >= BURST_W) ? BURST_L : rem[7:0];
  endfunction

  assign w_rem_left = r_rem - {24'd0, r_len};

  always_comb begin
    w_state_nxt    = r_state;
    w_src_nxt      = r_src;
    w_dst_nxt      = r_dst;
    w_rem_nxt      = r_rem;
    w_len_nxt      = r_len;
    w_set_int_nxt  = r_set_int;
    w_last_nxt     = r_last;
    w_next_nxt     = r_next;
    w_rd_req_nxt   = r_rd_req;
    w_wr_req_nxt   = r_wr_req;
    w_desc_req_nxt = r_desc_req;
    w_buf_cnt_nxt  = r_buf_cnt;
    w_int_cnt_nxt  = r_int_cnt;
    w_irq_nxt      = 1'b0;
    w_load         = 1'b0;
    w_enter_done   = 1'b0;
    w_ld_src       = io_dma.rd_start_addr;
    w_ld_dst       = io_dma.wr_start_addr;
    w_ld_size      = io_dma.buffer_size;
    w_ld_int       = io_dma.set_int;
    w_ld_last      = io_dma.cmd_last;
    w_ld_next      = io_dma.next_addr;

    case (r_state)
      S_IDLE: begin
        if (io_dma.ch_start) w_load = 1'b1;
      end
      S_RD: begin
        if (!r_rd_req) begin
          w_rd_req_nxt = 1'b1;
        end else if (io_dma.rd_ack) begin
          w_rd_req_nxt = 1'b0;
          w_state_nxt  = w_abort_now ? S_IDLE : S_WR;
        end
      end
      S_WR: begin
        if (!r_wr_req) begin
          w_wr_req_nxt = 1'b1;
        end else if (io_dma.wr_ack) begin
          w_wr_req_nxt = 1'b0;
          w_src_nxt    = r_src + {24'd0, r_len};
          w_dst_nxt    = r_dst + {24'd0, r_len};
          w_rem_nxt    = w_rem_left;
          if (w_abort_now) begin
            w_state_nxt = S_IDLE;
          end else if (w_rem_left != 32'd0) begin
            w_state_nxt = S_RD;
            w_len_nxt   = f_burst(w_rem_left);
          end else begin
            w_enter_done = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = r_last ? S_IDLE : S_FETCH;
      end
      S_FETCH: begin
        if (!r_desc_req) begin
          w_desc_req_nxt = 1'b1;
        end else if (io_dma.desc_ack) begin
          w_desc_req_nxt = 1'b0;
          if (w_abort_now) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_load    = 1'b1;
            w_ld_src  = io_dma.desc_rd_addr;
            w_ld_dst  = io_dma.desc_wr_addr;
            w_ld_size = io_dma.desc_size;
            w_ld_int  = io_dma.desc_set_int;
            w_ld_last = io_dma.desc_last;
            w_ld_next = io_dma.desc_next;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Shared by a fresh start and an accepted descriptor.
    if (w_load) begin
      w_src_nxt     = w_ld_src;
      w_dst_nxt     = w_ld_dst;
      w_rem_nxt     = w_ld_size;
      w_set_int_nxt = w_ld_int;
      w_last_nxt    = w_ld_last;
      w_next_nxt    = w_ld_next;
      if (w_ld_size == 32'd0) begin
        w_enter_done = 1'b1;
      end else begin
        w_state_nxt = S_RD;
        w_len_nxt   = f_burst(w_ld_size);
      end
    end

    // Counters and irq are registered on entry so they line up with the DONE cycle.
    if (w_enter_done) begin
      w_state_nxt   = S_DONE;
      w_buf_cnt_nxt = r_buf_cnt + 16'd1;
      if (w_set_int_nxt) begin
        w_int_cnt_nxt = r_int_cnt + 16'd1;
        w_irq_nxt     = 1'b1;
      end
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_src      <= 32'd0;
      r_dst      <= 32'd0;
      r_rem      <= 32'd0;
      r_len      <= 8'd0;
      r_set_int  <= 1'b0;
      r_last     <= 1'b0;
      r_next     <= 28'd0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_desc_req <= 1'b0;
      r_buf_cnt  <= 16'd0;
      r_int_cnt  <= 16'd0;
      r_irq      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_dst      <= w_dst_nxt;
      r_rem      <= w_rem_nxt;
      r_len      <= w_len_nxt;
      r_set_int  <= w_set_int_nxt;
      r_last     <= w_last_nxt;
      r_next     <= w_next_nxt;
      r_rd_req   <= w_rd_req_nxt;
      r_wr_req   <= w_wr_req_nxt;
      r_desc_req <= w_desc_req_nxt;
      r_buf_cnt  <= w_buf_cnt_nxt;
      r_int_cnt  <= w_int_cnt_nxt;
      r_irq      <= w_irq_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

`ifdef DMA_SEQ_ABORT_EN
  logic r_abort_pend;
  logic r_aborted;
  logic w_hs_state;

  assign w_hs_state  = (r_state == S_RD) || (r_state == S_WR) || (r_state == S_FETCH);
  // An abort is remembered until the outstanding handshake completes.
  assign w_abort_now = w_hs_state && (r_abort_pend || io_dma.ch_abort);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      if (w_state_nxt == S_IDLE) begin
        r_abort_pend <= 1'b0;
      end else if (w_hs_state && io_dma.ch_abort) begin
        r_abort_pend <= 1'b1;
      end
      if ((r_state == S_IDLE) && io_dma.ch_start) begin
        r_aborted <= 1'b0;
      end else if (w_abort_now && (w_state_nxt == S_IDLE)) begin
        r_aborted <= 1'b1;
      end
    end
  end

  assign io_dma.aborted = r_aborted;
`else
  assign w_abort_now = 1'b0;
`endif

  assign io_dma.rd_req       = r_rd_req;
  assign io_dma.rd_addr      = r_src;
  assign io_dma.rd_len       = r_len;
  assign io_dma.wr_req       = r_wr_req;
  assign io_dma.wr_addr      = r_dst;
  assign io_dma.wr_len       = r_len;
  assign io_dma.desc_req     = r_desc_req;
  assign io_dma.desc_addr    = {r_next, 4'b0000};
  assign io_dma.buffer_count = r_buf_cnt;
  assign io_dma.int_count    = r_int_cnt;
  assign io_dma.irq          = r_irq;
  assign io_dma.busy         = r_busy;

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Self-checking bench for dma_cmd_sequencer: randomized commands against a burst-list reference model.
module tb_dma_cmd_sequencer;
  localparam int BM = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_cmd_sequencer_if u_if ();
  dma_cmd_sequencer #(.BURST_MAX(BM)) u_dut (.clk(clk), .rst_n(rst_n), .io_dma(u_if));

  int n_err = 0;
  int n_chk = 0;
  logic [41:0] log_q[$];
  logic [41:0] exp_q[$];
  int irq_cycles = 0;
  int irq_run = 0;
  int viol = 0;
  bit ack_en = 1'b1;
  int ack_fixed = -1;
  int ack_cnt = 0;
  logic [15:0] exp_buf = 16'd0;
  logic [15:0] exp_int = 16'd0;

  // Reference: a command is a list of (read, write) burst pairs of at most BM bytes.
  function automatic void model_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] size);
    logic [31:0] rem;
    logic [7:0]  l;
    rem = size;
    while (rem != 32'd0) begin
      l = (rem > 32'(BM)) ? 8'(BM) : rem[7:0];
      exp_q.push_back({2'd0, src, l});
      exp_q.push_back({2'd1, dst, l});
      src = src + 32'(l);
      dst = dst + 32'(l);
      rem = rem - 32'(l);
    end
  endfunction

  function automatic int first_diff();
    int n;
    n = (log_q.size() > exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= log_q.size() || i >= exp_q.size()) return i;
      if (log_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [41:0] log_at(input int i);
    return (i >= 0 && i < log_q.size()) ? log_q[i] : 42'd0;
  endfunction

  function automatic logic [41:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 42'd0;
  endfunction

  // Monitor: samples just before each rising edge what the DUT will see.
  initial begin
    logic [31:0] p_addr, c_addr;
    logic [7:0]  p_len, c_len;
    bit          p_wait, any_req, acked;
    p_wait = 1'b0;
    p_addr = 32'd0;
    p_len  = 8'd0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        p_wait  = 1'b0;
        irq_run = 0;
      end else begin
        if ((int'(u_if.rd_req) + int'(u_if.wr_req) + int'(u_if.desc_req)) > 1) viol++;
        any_req = u_if.rd_req || u_if.wr_req || u_if.desc_req;
        acked = (u_if.rd_req && u_if.rd_ack) || (u_if.wr_req && u_if.wr_ack) ||
                (u_if.desc_req && u_if.desc_ack);
        c_addr = u_if.rd_req ? u_if.rd_addr : (u_if.wr_req ? u_if.wr_addr : u_if.desc_addr);
        c_len  = u_if.rd_req ? u_if.rd_len : (u_if.wr_req ? u_if.wr_len : 8'd0);
        if (p_wait && (!any_req || c_addr !== p_addr || c_len !== p_len)) viol++;
        if (u_if.rd_req && u_if.rd_ack) log_q.push_back({2'd0, u_if.rd_addr, u_if.rd_len});
        if (u_if.wr_req && u_if.wr_ack) log_q.push_back({2'd1, u_if.wr_addr, u_if.wr_len});
        if (u_if.desc_req && u_if.desc_ack) log_q.push_back({2'd2, u_if.desc_addr, 8'd0});
        p_wait = any_req && !acked;
        p_addr = c_addr;
        p_len  = c_len;
        if (u_if.irq) begin
          irq_cycles++;
          irq_run++;
          if (irq_run > 1) viol++;
        end else begin
          irq_run = 0;
        end
      end
    end
  end

  // Responder: acks the active request after 0..3 (or a fixed number of) cycles.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        u_if.rd_ack = 1'b0; u_if.wr_ack = 1'b0; u_if.desc_ack = 1'b0;
        ack_cnt = 0;
      end else if (u_if.rd_ack || u_if.wr_ack || u_if.desc_ack) begin
        u_if.rd_ack = 1'b0; u_if.wr_ack = 1'b0; u_if.desc_ack = 1'b0;
      end else if (!(u_if.rd_req || u_if.wr_req || u_if.desc_req)) begin
        ack_cnt = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
      end else if (ack_en) begin
        if (ack_cnt == 0) begin
          u_if.rd_ack   = u_if.rd_req;
          u_if.wr_ack   = u_if.wr_req;
          u_if.desc_ack = u_if.desc_req;
        end else begin
          ack_cnt--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] size,
                           input logic si, input logic last, input logic [27:0] nxt);
    @(negedge clk);
    u_if.rd_start_addr = src;
    u_if.wr_start_addr = dst;
    u_if.buffer_size   = size;
    u_if.set_int       = si;
    u_if.cmd_last      = last;
    u_if.next_addr     = nxt;
    u_if.ch_start      = 1'b1;
    @(negedge clk);
    u_if.ch_start      = 1'b0;
  endtask

  task automatic wait_idle(input bit noise, output bit tmo);
    int cyc;
    cyc = 0;
    while (u_if.busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (noise && cyc == 3 && u_if.busy) begin
        u_if.rd_start_addr = $urandom;
        u_if.wr_start_addr = $urandom;
        u_if.buffer_size   = 32'($urandom_range(1, 50));
        u_if.cmd_last      = 1'b1;
        u_if.ch_start      = 1'b1;
      end else begin
        u_if.ch_start = 1'b0;
      end
    end
    u_if.ch_start = 1'b0;
    tmo = (cyc >= 3000);
  endtask

  task automatic run_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] size,
                         input logic si, input logic last, input logic [27:0] nxt,
                         input bit noise, output bit tmo);
    start_cmd(src, dst, size, si, last, nxt);
    wait_idle(noise, tmo);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.ch_start = 1'b0;
    u_if.rd_start_addr = 32'd0; u_if.wr_start_addr = 32'd0; u_if.buffer_size = 32'd0;
    u_if.set_int = 1'b0; u_if.cmd_last = 1'b0; u_if.next_addr = 28'd0;
    u_if.desc_rd_addr = 32'd0; u_if.desc_wr_addr = 32'd0; u_if.desc_size = 32'd0;
    u_if.desc_set_int = 1'b0; u_if.desc_last = 1'b0; u_if.desc_next = 28'd0;
`ifdef DMA_SEQ_ABORT_EN
    u_if.ch_abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_chk++; if (u_if.rd_req !== 1'b0) begin n_err++; $display("FAIL reset_rd_req got=%b exp=0", u_if.rd_req); end
    n_chk++; if (u_if.wr_req !== 1'b0) begin n_err++; $display("FAIL reset_wr_req got=%b exp=0", u_if.wr_req); end
    n_chk++; if (u_if.desc_req !== 1'b0) begin n_err++; $display("FAIL reset_desc_req got=%b exp=0", u_if.desc_req); end
    n_chk++; if (u_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", u_if.busy); end
    n_chk++; if (u_if.irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", u_if.irq); end
    n_chk++; if (u_if.buffer_count !== 16'd0) begin n_err++; $display("FAIL reset_buffer_count got=%0d exp=0", u_if.buffer_count); end
    n_chk++; if (u_if.int_count !== 16'd0) begin n_err++; $display("FAIL reset_int_count got=%0d exp=0", u_if.int_count); end
    n_chk++; if (u_if.rd_addr !== 32'd0) begin n_err++; $display("FAIL reset_rd_addr got=%h exp=0", u_if.rd_addr); end
`ifdef DMA_SEQ_ABORT_EN
    n_chk++; if (u_if.aborted !== 1'b0) begin n_err++; $display("FAIL reset_aborted got=%b exp=0", u_if.aborted); end
`endif
    rst_n = 1'b1;
    exp_buf = 16'd0;
    exp_int = 16'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_example(input logic si);
    bit tmo;
    int d;
    log_q.delete(); exp_q.delete(); irq_cycles = 0;
    run_cmd(32'h1000, 32'h2000, 32'd100, si, 1'b1, 28'd0, 1'b0, tmo);
    exp_q.push_back({2'd0, 32'h1000, 8'd64});
    exp_q.push_back({2'd1, 32'h2000, 8'd64});
    exp_q.push_back({2'd0, 32'h1040, 8'd36});
    exp_q.push_back({2'd1, 32'h2040, 8'd36});
    exp_buf = exp_buf + 16'd1;
    if (si) exp_int = exp_int + 16'd1;
    n_chk++; if (tmo) begin n_err++; $display("FAIL example_timeout got=busy exp=idle"); end
    d = first_diff();
    n_chk++; if (d != -1) begin n_err++; $display("FAIL example_bursts idx=%0d got=%h exp=%h", d, log_at(d), exp_at(d)); end
    n_chk++; if (u_if.buffer_count !== exp_buf) begin n_err++; $display("FAIL example_buffer_count got=%0d exp=%0d", u_if.buffer_count, exp_buf); end
    n_chk++; if (u_if.int_count !== exp_int) begin n_err++; $display("FAIL example_int_count got=%0d exp=%0d", u_if.int_count, exp_int); end
    n_chk++; if (irq_cycles != int'(si)) begin n_err++; $display("FAIL example_irq_cycles got=%0d exp=%0d", irq_cycles, si); end
    n_chk++; if (u_if.busy !== 1'b0) begin n_err++; $display("FAIL example_busy got=%b exp=0", u_if.busy); end
  endtask

  task automatic test_random();
    bit tmo;
    int d;
    logic [31:0] src, dst, size;
    logic si;
    for (int i = 0; i < 8; i++) begin
      log_q.delete(); exp_q.delete(); irq_cycles = 0;
      src  = (i == 0) ? 32'hFFFF_FFD0 : $urandom;
      dst  = (i == 1) ? 32'hFFFF_FFF8 : $urandom;
      size = 32'($urandom_range(0, 300));
      si   = 1'($urandom_range(0, 1));
      run_cmd(src, dst, size, si, 1'b1, 28'd0, 1'($urandom_range(0, 1)), tmo);
      model_cmd(src, dst, size);
      exp_buf = exp_buf + 16'd1;
      if (si) exp_int = exp_int + 16'd1;
      n_chk++; if (tmo) begin n_err++; $display("FAIL random_timeout iter=%0d got=busy exp=idle", i); end
      d = first_diff();
      n_chk++; if (d != -1) begin n_err++; $display("FAIL random_bursts iter=%0d size=%0d idx=%0d got=%h exp=%h", i, size, d, log_at(d), exp_at(d)); end
      n_chk++; if (u_if.buffer_count !== exp_buf) begin n_err++; $display("FAIL random_buffer_count iter=%0d got=%0d exp=%0d", i, u_if.buffer_count, exp_buf); end
      n_chk++; if (u_if.int_count !== exp_int) begin n_err++; $display("FAIL random_int_count iter=%0d got=%0d exp=%0d", i, u_if.int_count, exp_int); end
      n_chk++; if (irq_cycles != int'(si)) begin n_err++; $display("FAIL random_irq_cycles iter=%0d got=%0d exp=%0d", i, irq_cycles, si); end
    end
  endtask

  task automatic test_chain();
    bit tmo;
    int d;
    logic [31:0] src, dst, size;
    logic si;
    log_q.delete(); exp_q.delete(); irq_cycles = 0;
    src  = $urandom;
    dst  = $urandom;
    size = 32'($urandom_range(1, 150));
    si   = 1'($urandom_range(0, 1));
    u_if.desc_rd_addr = $urandom;
    u_if.desc_wr_addr = $urandom;
    u_if.desc_size    = 32'd64;
    u_if.desc_set_int = 1'($urandom_range(0, 1));
    u_if.desc_last    = 1'b1;
    u_if.desc_next    = 28'($urandom);
    run_cmd(src, dst, size, si, 1'b0, 28'h0000010, 1'b0, tmo);
    model_cmd(src, dst, size);
    exp_q.push_back({2'd2, 32'h0000_0100, 8'd0});
    model_cmd(u_if.desc_rd_addr, u_if.desc_wr_addr, 32'd64);
    exp_buf = exp_buf + 16'd2;
    exp_int = exp_int + 16'(si) + 16'(u_if.desc_set_int);
    n_chk++; if (tmo) begin n_err++; $display("FAIL chain_timeout got=busy exp=idle"); end
    d = first_diff();
    n_chk++; if (d != -1) begin n_err++; $display("FAIL chain_bursts idx=%0d got=%h exp=%h", d, log_at(d), exp_at(d)); end
    n_chk++; if (u_if.buffer_count !== exp_buf) begin n_err++; $display("FAIL chain_buffer_count got=%0d exp=%0d", u_if.buffer_count, exp_buf); end
    n_chk++; if (u_if.int_count !== exp_int) begin n_err++; $display("FAIL chain_int_count got=%0d exp=%0d", u_if.int_count, exp_int); end
  endtask

  task automatic test_zero_size();
    bit tmo;
    int cyc;
    logic [15:0] b0;
    log_q.delete();
    b0 = u_if.buffer_count;
    @(negedge clk);
    u_if.buffer_size = 32'd0; u_if.set_int = 1'b1; u_if.cmd_last = 1'b1;
    u_if.ch_start = 1'b1;
    cyc = 0;
    while (u_if.buffer_count === b0 && cyc < 10) begin
      @(negedge clk);
      u_if.ch_start = 1'b0;
      cyc++;
    end
    u_if.ch_start = 1'b0;
    wait_idle(1'b0, tmo);
    exp_buf = exp_buf + 16'd1;
    exp_int = exp_int + 16'd1;
    n_chk++; if (cyc > 3) begin n_err++; $display("FAIL zero_latency got=%0d exp<=3 cycles", cyc); end
    n_chk++; if (log_q.size() != 0) begin n_err++; $display("FAIL zero_no_bursts got=%0d exp=0 transfers", log_q.size()); end
    n_chk++; if (u_if.buffer_count !== exp_buf) begin n_err++; $display("FAIL zero_buffer_count got=%0d exp=%0d", u_if.buffer_count, exp_buf); end
  endtask

  task automatic test_ack_hold();
    bit tmo, stable, seen;
    int d;
    logic [31:0] a0;
    logic [7:0]  l0;
    log_q.delete(); exp_q.delete();
    ack_fixed = 5;
    start_cmd(32'h0000_3000, 32'h0000_4000, 32'd40, 1'b0, 1'b1, 28'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (u_if.rd_req) seen = 1'b1; else @(negedge clk);
    end
    a0 = u_if.rd_addr;
    l0 = u_if.rd_len;
    stable = seen && a0 === 32'h0000_3000 && l0 === 8'd40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (u_if.rd_req !== 1'b1 || u_if.rd_addr !== a0 || u_if.rd_len !== l0) stable = 1'b0;
    end
    n_chk++; if (!stable) begin n_err++; $display("FAIL hold_stable got=addr %h len %0d exp=addr 00003000 len 40 held 5 cycles", u_if.rd_addr, u_if.rd_len); end
    wait_idle(1'b0, tmo);
    ack_fixed = -1;
    model_cmd(32'h0000_3000, 32'h0000_4000, 32'd40);
    exp_buf = exp_buf + 16'd1;
    d = first_diff();
    n_chk++; if (tmo || d != -1) begin n_err++; $display("FAIL hold_bursts idx=%0d got=%h exp=%h", d, log_at(d), exp_at(d)); end
  endtask

  task automatic test_reset_mid();
    bit tmo, seen;
    int d;
    ack_en = 1'b0;
    start_cmd(32'h0000_5000, 32'h0000_6000, 32'd100, 1'b1, 1'b1, 28'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (u_if.rd_req) seen = 1'b1; else @(negedge clk);
    end
    n_chk++; if (!seen) begin n_err++; $display("FAIL midreset_rd_req_rise got=0 exp=1"); end
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++; if (u_if.rd_req !== 1'b0) begin n_err++; $display("FAIL midreset_rd_req got=%b exp=0", u_if.rd_req); end
    n_chk++; if (u_if.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got=%b exp=0", u_if.busy); end
    n_chk++; if (u_if.buffer_count !== 16'd0 || u_if.int_count !== 16'd0) begin
      n_err++; $display("FAIL midreset_counts got=%0d/%0d exp=0/0", u_if.buffer_count, u_if.int_count);
    end
    exp_buf = 16'd0;
    exp_int = 16'd0;
    repeat (2) @(negedge clk);
    ack_en = 1'b1;
    rst_n = 1'b1;
    log_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (u_if.rd_req || u_if.wr_req || u_if.desc_req || u_if.busy) seen = 1'b1;
    end
    n_chk++; if (seen) begin n_err++; $display("FAIL midreset_no_resume got=activity exp=idle"); end
    log_q.delete(); exp_q.delete();
    run_cmd(32'h0000_7000, 32'h0000_8000, 32'd70, 1'b0, 1'b1, 28'd0, 1'b0, tmo);
    model_cmd(32'h0000_7000, 32'h0000_8000, 32'd70);
    exp_buf = exp_buf + 16'd1;
    d = first_diff();
    n_chk++; if (tmo || d != -1) begin n_err++; $display("FAIL midreset_restart idx=%0d got=%h exp=%h", d, log_at(d), exp_at(d)); end
    n_chk++; if (u_if.buffer_count !== exp_buf) begin n_err++; $display("FAIL midreset_buffer_count got=%0d exp=%0d", u_if.buffer_count, exp_buf); end
  endtask

`ifdef DMA_SEQ_ABORT_EN
  task automatic test_abort();
    bit tmo, seen;
    int d;
    log_q.delete(); exp_q.delete(); irq_cycles = 0;
    start_cmd(32'h0000_9000, 32'h0000_A000, 32'd200, 1'b1, 1'b1, 28'd0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (u_if.wr_req) seen = 1'b1; else @(negedge clk);
    end
    u_if.ch_abort = 1'b1;
    @(negedge clk);
    u_if.ch_abort = 1'b0;
    wait_idle(1'b0, tmo);
    exp_q.push_back({2'd0, 32'h0000_9000, 8'd64});
    exp_q.push_back({2'd1, 32'h0000_A000, 8'd64});
    d = first_diff();
    n_chk++; if (tmo || !seen || d != -1) begin n_err++; $display("FAIL abort_bursts idx=%0d got=%h exp=%h", d, log_at(d), exp_at(d)); end
    n_chk++; if (u_if.aborted !== 1'b1) begin n_err++; $display("FAIL abort_flag got=%b exp=1", u_if.aborted); end
    n_chk++; if (u_if.buffer_count !== exp_buf || irq_cycles != 0) begin
      n_err++; $display("FAIL abort_no_done got=%0d irq=%0d exp=%0d irq=0", u_if.buffer_count, irq_cycles, exp_buf);
    end
    run_cmd(32'h0000_B000, 32'h0000_C000, 32'd10, 1'b0, 1'b1, 28'd0, 1'b0, tmo);
    exp_buf = exp_buf + 16'd1;
    n_chk++; if (u_if.aborted !== 1'b0) begin n_err++; $display("FAIL abort_clear got=%b exp=0", u_if.aborted); end
  endtask
`endif

  initial begin
    test_reset();
    test_example(1'b1);
    test_example(1'b0);
    test_random();
    test_chain();
    test_zero_size();
    test_ack_hold();
`ifdef DMA_SEQ_ABORT_EN
    test_abort();
`endif
    test_reset_mid();
    n_chk++; if (viol != 0) begin n_err++; $display("FAIL protocol_violations got=%0d exp=0", viol); end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
